// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter of icache/dcache misses onto one memory bridge port
module cache_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_ena,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_read_valid,
    output logic [DATA_W-1:0] i_read_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_read_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

    // Compared against the count including the current cycle, so 9 bits avoid wrap at 255
    localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT);

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                bus_err_q, bus_err_d;
    logic                in_gnt, timeout_hit, finish, pick_d;

    // Completion pulses pass mem_rdata straight through; a timeout completes with zero data
    always_comb begin
        in_gnt       = (state_q == GNT_I) || (state_q == GNT_D);
        timeout_hit  = in_gnt && !mem_done && (({1'b0, cnt_q} + 9'd1) == TIMEOUT_L);
        finish       = in_gnt && (mem_done || timeout_hit);
        i_read_valid = finish && (state_q == GNT_I);
        d_done       = finish && (state_q == GNT_D);
        i_read_data  = ((state_q == GNT_I) && mem_done) ? mem_rdata : '0;
        d_read_data  = ((state_q == GNT_D) && mem_done) ? mem_rdata : '0;
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

    // Next-state: grant in IDLE (tie goes opposite last grant), finish on done or timeout
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_err_d   = bus_err_q;
        pick_d      = d_req && (!i_read_ena || !last_d_q);
        case (state_q)
            IDLE: begin
                if (i_read_ena || d_req) begin
                    state_d     = pick_d ? GNT_D : GNT_I;
                    last_d_d    = pick_d;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_d && d_we;
                    mem_addr_d  = pick_d ? d_addr : i_addr;
                    mem_wdata_d = pick_d ? d_wdata : '0;
                end
            end
            GNT_I, GNT_D: begin
                if (finish) begin
                    state_d   = RELEASE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (timeout_hit) begin
                        bus_err_d = 1'b1;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered bridge-side outputs; reset drops everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter with a transaction-level model
module tb_cache_mem_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read_ena = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_done = 1'b0;
    logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        i_read_valid, d_done, mem_req, mem_we, bus_err;
    logic [63:0] i_read_data, d_read_data, mem_addr, mem_wdata;

    cache_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read_ena(i_read_ena), .i_addr(i_addr),
        .i_read_valid(i_read_valid), .i_read_data(i_read_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_read_data(d_read_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who_d;
        bit          is_read;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the bus: phase 0 free, 1 owned, 2 handover cycle
    int          m_st = 0, g = 0, lat = 0, ngrant = 0, gap_i = 0, gap_d = 0;
    bit          m_last_d = 1'b0, m_who_d = 1'b0, m_err = 1'b0, allow_to = 1'b0;
    bit          e_we;
    logic [63:0] e_addr, e_wdata, rdata;

    task automatic step();
        bit          n_ri, n_rd, n_we, n_done, fin_i, fin_d;
        logic [63:0] n_ia, n_da, n_dw;
        @(negedge clk);
        fin_i = 1'b0;
        fin_d = 1'b0;
        case (m_st)
            0: begin
                check("idle_mem_req", mem_req, 1'b0);
                if (i_read_ena || d_req) begin
                    m_who_d  = d_req && (!i_read_ena || !m_last_d);
                    m_last_d = m_who_d;
                    e_addr   = m_who_d ? d_addr : i_addr;
                    e_we     = m_who_d && d_we;
                    e_wdata  = d_wdata;
                    if (allow_to && $urandom_range(0, 1) == 0) lat = 100;
                    else if (ngrant < 2) lat = 3;
                    else if (ngrant == 2) lat = TO - 1;
                    else lat = $urandom_range(1, TO - 1);
                    rdata = (ngrant < 2) ? 64'h1234_5678_9ABC_DEF0 : {$urandom, $urandom};
                    sb.push_back('{m_who_d, !e_we, (lat >= TO) ? 64'h0 : rdata});
                    g = 0;
                    m_st = 1;
                    ngrant++;
                end
            end
            1: begin
                check("gnt_mem_req", mem_req, 1'b1);
                check("gnt_mem_addr", mem_addr, e_addr);
                check("gnt_mem_we", mem_we, e_we);
                if (e_we) check("gnt_mem_wdata", mem_wdata, e_wdata);
                if (g == lat || g == TO - 1) begin
                    if (g != lat) m_err = 1'b1;
                    fin_i = !m_who_d;
                    fin_d = m_who_d;
                    m_st = 2;
                end else begin
                    g++;
                end
            end
            default: begin
                check("rel_mem_req", mem_req, 1'b0);
                check("rel_bus_err", bus_err, m_err);
                m_st = 0;
            end
        endcase
        // Requesters hold until their pulse, drop for the handover cycle, then re-request later
        n_ri = i_read_ena; n_rd = d_req;
        n_ia = i_addr; n_da = d_addr; n_dw = d_wdata; n_we = d_we;
        if (fin_i) begin n_ri = 1'b0; gap_i = $urandom_range(0, 4); end
        else if (!n_ri) begin if (gap_i == 0) n_ri = 1'b1; else gap_i--; end
        if (fin_d) begin n_rd = 1'b0; gap_d = $urandom_range(0, 4); end
        else if (!n_rd) begin if (gap_d == 0) n_rd = 1'b1; else gap_d--; end
        if (ngrant >= 2 && $urandom_range(0, 1) == 1) begin
            n_ia = {32'h8000_0000, $urandom} & ~64'h7;
            n_da = {32'h9000_0000, $urandom} & ~64'h7;
            n_dw = {$urandom, $urandom};
            n_we = $urandom_range(0, 1);
        end
        if (m_st == 1) n_done = (g == lat);
        else n_done = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        #1;
        i_read_ena = n_ri; d_req = n_rd;
        i_addr = n_ia; d_addr = n_da; d_wdata = n_dw; d_we = n_we;
        mem_done = n_done;
        mem_rdata = n_done ? rdata : {$urandom, $urandom};
    endtask

    // Monitor: every completion pulse must match the oldest outstanding grant
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_read_valid || d_done) begin
                check("single_pulse", i_read_valid & d_done, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {i_read_valid, d_done}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("pulse_owner", d_done, e.who_d);
                    if (e.is_read)
                        check("pulse_rdata", d_done ? d_read_data : i_read_data, e.data);
                end
            end
        end
    end

    initial begin
        int n;
        i_read_ena = 1'b1; i_addr = 64'h8000_0010;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8000_0100; d_wdata = 64'hAA;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_pulses", {i_read_valid, d_done}, 2'b00);
        check("rst_mem_addr", mem_addr, 64'h0);
        #6 rst = 1'b0;

        repeat (400) step();
        check("no_err_before_timeouts", bus_err, 1'b0);

        allow_to = 1'b1;
        repeat (200) step();
        allow_to = 1'b0;
        check("sticky_bus_err", bus_err, m_err);

        n = 0;
        while (!(m_st == 1 && m_who_d && g >= 1) && n < 200) begin
            step();
            n++;
        end
        check("reached_gnt_d", n < 200, 1'b1);
        #1 rst = 1'b1;
        mem_done = 1'b1;
        #1;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_mem_we", mem_we, 1'b0);
        check("midrst_pulses", {i_read_valid, d_done}, 2'b00);
        check("midrst_bus_err", bus_err, 1'b0);
        sb.delete();
        m_st = 0; m_last_d = 1'b0; m_err = 1'b0; gap_i = 0; gap_d = 0;
        i_read_ena = 1'b1; i_addr = 64'h8000_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_0200;
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        check("post_rst_tie_to_d", m_who_d, 1'b1);
        repeat (60) step();
        check("post_rst_no_err", bus_err, 1'b0);
        check("sb_drained", sb.size() <= 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the single downstream memory/AXI bridge port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits between `i_cache`/`d_cache` and the AXI4 master bridge.
- Grants one transaction at a time using round-robin arbitration.
- Routes returned read data to the granted cache and flags bus timeouts.

Parameters:
- ADDR_W, 64, address width of all address ports.
- DATA_W, 64, data width of all data ports.
- TIMEOUT, 255, maximum cycles to wait for mem_done before abort (8-bit counter; must be 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_read_ena  in  1  icache read request; held high until i_read_valid
- i_addr  in  ADDR_W  icache read address, 8-byte aligned
- i_read_valid  out  1  one-cycle pulse: i_read_data valid, icache transaction done
- i_read_data  out  DATA_W  read data to icache
- d_req  in  1  dcache request; held high until d_done
- d_we  in  1  dcache request type: 1=write, 0=read
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  DATA_W  dcache write data
- d_done  out  1  one-cycle pulse: dcache transaction complete
- d_read_data  out  DATA_W  read data to dcache
- mem_req  out  1  request to bridge; held until mem_done
- mem_we  out  1  write strobe to bridge
- mem_addr  out  ADDR_W  address to bridge
- mem_wdata  out  DATA_W  write data to bridge
- mem_done  in  1  one-cycle completion pulse from bridge
- mem_rdata  in  DATA_W  read data, valid with mem_done
- bus_err  out  1  sticky: a transaction timed out; cleared only by rst

Behaviour:
- States: IDLE, GNT_I, GNT_D, RELEASE.
- Reset (async, rst=1):
  - State=IDLE, last_grant=I, timeout counter=0.
  - All outputs 0, including bus_err.
- Data latching:
  - Captured address, data and type are registered on the grant transition.
  - Requester inputs changing during a grant are ignored.
- IDLE:
  - Only i_read_ena → GNT_I.
  - Only d_req → GNT_D.
  - Both requesting → grant the requester opposite last_grant. The first tie after reset therefore goes to dcache.
  - On any grant, update last_grant.
- GNT_I:
  - mem_req=1, mem_we=0, mem_addr=latched i_addr.
  - On mem_done: i_read_valid=1 and i_read_data=mem_rdata in the same cycle (combinational pass-through), then → RELEASE.
- GNT_D:
  - mem_req=1, mem_we=latched d_we, mem_addr/mem_wdata latched.
  - On mem_done: d_done=1, d_read_data=mem_rdata (don't-care for writes), then → RELEASE.
- RELEASE:
  - Lasts one cycle with all handshake outputs 0, then → IDLE.
  - Gives the requester a cycle to drop its ena. A request still high in IDLE is treated as a new request.
- Grant latency:
  - Request seen in IDLE → mem_req high the next cycle.
  - Minimum turnaround from mem_done to the next grant is 2 cycles.
- Timeout:
  - An 8-bit counter clears on entry to GNT_*, increments each cycle mem_done=0, and saturates.
  - When the counter reaches TIMEOUT with no mem_done:
    - Deassert mem_req.
    - Pulse the granted requester's valid/done with data=0.
    - Set bus_err, go to RELEASE.
  - mem_done arriving in that same cycle takes precedence: normal completion, no error.
- Bridge protocol violations:
  - mem_done in IDLE or RELEASE is ignored; no output pulses.
  - mem_req never drops between grant and mem_done, and addr/we/wdata are stable throughout.
- Output encoding: i_read_valid and d_done are never high in the same cycle, and at most one of GNT_I/GNT_D is active.
- Mid-transaction reset: all outputs drop immediately. The bridge must discard its in-flight transfer on the same rst.

Test Plan:
- Single icache read, addr=0x8000_0010, bridge returns 0x1234_5678_9ABC_DEF0 after 3 cycles → mem_req 1 cycle after ena, i_read_valid pulse with that data, RELEASE, IDLE.
- i_read_ena and d_req (write, addr 0x8000_0100, data 0xAA) rise together after reset → dcache granted first with mem_we=1; icache granted 2 cycles after mem_done.
- Both held continuously for 4 transactions → grants alternate D,I,D,I; no back-to-back same requester while the other waits.
- Bridge never answers, TIMEOUT=8 → mem_req drops after 8 cycles in grant, requester pulse with data=0, bus_err=1 and stays 1.
- mem_done on the exact TIMEOUT cycle → normal completion, bus_err stays 0.
- Assert rst mid-GNT_D and spurious mem_done in IDLE → outputs zero asynchronously; no pulses, last_grant reset (next tie → dcache).
